// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkg
// Brief    : Shared NoC types for the collector drain path.
// Revision : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int NOC_NODE_COUNT = 8;
    localparam int NODE_W         = $clog2(NOC_NODE_COUNT);
    localparam int NOC_PKT_ID_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } drain_state_t;

    typedef struct packed {
        logic [NODE_W-1:0]       node_start;
        logic [NODE_W-1:0]       node_dest;
        logic [NOC_PKT_ID_W-1:0] packet_id;
    } packet_meta_t;

endpackage
`default_nettype wire

// File: rtl/collector_drain_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Cyclic first-set search over req, starting at ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0]         req,
    input  logic [$clog2(N_SRC)-1:0] ptr,
    output logic [$clog2(N_SRC)-1:0] idx,
    output logic                     any
);

    localparam int IDX_W = $clog2(N_SRC);

    logic [31:0] cand;

    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < N_SRC; i++) begin
            // ptr < N_SRC, so a single subtraction performs the wrap
            cand = 32'(ptr) + 32'(i);
            if (cand >= 32'(N_SRC)) begin
                cand = cand - 32'(N_SRC);
            end
            if (!any && req[cand[IDX_W-1:0]]) begin
                any = 1'b1;
                idx = cand[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/collector_drain_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : collector_drain_arbiter
// Brief    : Round-robin poller draining N_SRC packet collectors to one port.
// Revision : 1.0 - initial release
// ============================================================================
module collector_drain_arbiter
    import noc_pkg::*;
#(
    parameter int N_SRC           = 4,
    parameter int NODE_COUNT      = 8,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int PAYLOAD         = 32,
    parameter int TIMEOUT         = 15
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     en,
    input  logic [N_SRC-1:0]                         src_en,
    input  logic [N_SRC-1:0]                         src_valid,
    input  logic [N_SRC*PAYLOAD-1:0]                 src_packet,
    input  logic [N_SRC*$clog2(NODE_COUNT)-1:0]      src_node_start,
    input  logic [N_SRC*$clog2(NODE_COUNT)-1:0]      src_node_dest,
    input  logic [N_SRC*PACKET_ID_WIDTH-1:0]         src_packet_id,
    output logic [N_SRC-1:0]                         src_send,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [PAYLOAD-1:0]                       out_packet,
    output logic [$clog2(NODE_COUNT)-1:0]            out_node_start,
    output logic [$clog2(NODE_COUNT)-1:0]            out_node_dest,
    output logic [PACKET_ID_WIDTH-1:0]               out_packet_id,
    output logic [$clog2(N_SRC)-1:0]                 out_src,
    output logic [15:0]                              pkt_count,
    output logic [7:0]                               timeout_count
);

    localparam int NODE_BITS = $clog2(NODE_COUNT);
    localparam int IDX_W     = $clog2(N_SRC);
    localparam int TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SRC - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

    drain_state_t                 state_q, state_d;
    logic [IDX_W-1:0]             ptr_q, ptr_d;
    logic [IDX_W-1:0]             grant_q, grant_d;
    logic [TMO_W-1:0]             tmo_q, tmo_d;
    logic                         out_valid_q, out_valid_d;
    logic [PAYLOAD-1:0]           out_packet_q, out_packet_d;
    logic [NODE_BITS-1:0]         out_node_start_q, out_node_start_d;
    logic [NODE_BITS-1:0]         out_node_dest_q, out_node_dest_d;
    logic [PACKET_ID_WIDTH-1:0]   out_packet_id_q, out_packet_id_d;
    logic [IDX_W-1:0]             out_src_q, out_src_d;
    logic [15:0]                  pkt_count_q, pkt_count_d;
    logic [7:0]                   timeout_count_q, timeout_count_d;

    logic [IDX_W-1:0]             pick_idx;
    logic                         pick_any;
    logic [IDX_W-1:0]             grant_next;

    rr_pick #(
        .N_SRC (N_SRC)
    ) u_rr_pick (
        .req (src_en),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign grant_next = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;

    // Send strobe depends only on registered state so collectors see no comb path
    for (genvar i = 0; i < N_SRC; i++) begin : g_send
        assign src_send[i] = (state_q == REQ) && (grant_q == IDX_W'(i));
    end

    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        grant_d          = grant_q;
        tmo_d            = tmo_q;
        out_valid_d      = out_valid_q;
        out_packet_d     = out_packet_q;
        out_node_start_d = out_node_start_q;
        out_node_dest_d  = out_node_dest_q;
        out_packet_id_d  = out_packet_id_q;
        out_src_d        = out_src_q;
        pkt_count_d      = pkt_count_q;
        timeout_count_d  = timeout_count_q;

        case (state_q)
            IDLE: begin
                if (en && pick_any) begin
                    grant_d = pick_idx;
                    tmo_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (src_valid[grant_q]) begin
                    out_packet_d     = src_packet[int'(grant_q)*PAYLOAD +: PAYLOAD];
                    out_node_start_d = src_node_start[int'(grant_q)*NODE_BITS +: NODE_BITS];
                    out_node_dest_d  = src_node_dest[int'(grant_q)*NODE_BITS +: NODE_BITS];
                    out_packet_id_d  = src_packet_id[int'(grant_q)*PACKET_ID_WIDTH +: PACKET_ID_WIDTH];
                    out_src_d        = grant_q;
                    out_valid_d      = 1'b1;
                    state_d          = HOLD;
                end else if (!src_en[grant_q]) begin
                    // Source withdrawn mid-poll: move on without charging a timeout
                    ptr_d   = grant_next;
                    state_d = IDLE;
                end else if (tmo_q == TMO_MAX) begin
                    if (timeout_count_q != 8'hFF) begin
                        timeout_count_d = timeout_count_q + 8'd1;
                    end
                    ptr_d   = grant_next;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    pkt_count_d = pkt_count_q + 16'd1;
                    ptr_d       = grant_next;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            ptr_q            <= '0;
            grant_q          <= '0;
            tmo_q            <= '0;
            out_valid_q      <= 1'b0;
            out_packet_q     <= '0;
            out_node_start_q <= '0;
            out_node_dest_q  <= '0;
            out_packet_id_q  <= '0;
            out_src_q        <= '0;
            pkt_count_q      <= '0;
            timeout_count_q  <= '0;
        end else begin
            state_q          <= state_d;
            ptr_q            <= ptr_d;
            grant_q          <= grant_d;
            tmo_q            <= tmo_d;
            out_valid_q      <= out_valid_d;
            out_packet_q     <= out_packet_d;
            out_node_start_q <= out_node_start_d;
            out_node_dest_q  <= out_node_dest_d;
            out_packet_id_q  <= out_packet_id_d;
            out_src_q        <= out_src_d;
            pkt_count_q      <= pkt_count_d;
            timeout_count_q  <= timeout_count_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_packet     = out_packet_q;
    assign out_node_start = out_node_start_q;
    assign out_node_dest  = out_node_dest_q;
    assign out_packet_id  = out_packet_id_q;
    assign out_src        = out_src_q;
    assign pkt_count      = pkt_count_q;
    assign timeout_count  = timeout_count_q;

endmodule
`default_nettype wire
